wb_writeback_unit: RTL and testbench

Parametrised, registered writeback stage for the RISC-V pipeline. It sits between the MEM/WB pipeline register and the register-file write port. It selects among the ALU result, load data, and PC+4, and sign- or zero-extends sub-word loads. It stalls the pipeline through a valid/ready handshake while a load response is outstanding, and counts retired instructions.

---
 rtl/wb_writeback_unit.sv | 141 ++++++++++++++
 tb/tb_wb_writeback_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_unit.sv
// Registered RISC-V writeback stage: picks ALU / load / PC+4 results, extends sub-word loads,
// stalls on outstanding load data through ReadyW, and counts retired instructions.
module wb_writeback_unit #(
    parameter  int XLEN  = 64,
    parameter  int CNT_W = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidW,
    output logic             ReadyW,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcW,
    input  logic [2:0]       Funct3W,
    input  logic [OFF_W-1:0] ByteOffW,
    input  logic [XLEN-1:0]  ALU_ResultW,
    input  logic [XLEN-1:0]  PCPlus4W,
    input  logic [XLEN-1:0]  ReadDataW,
    input  logic             ReadValidW,
    input  logic [4:0]       RD_W,
    output logic             RF_WE,
    output logic [4:0]       RF_Addr,
    output logic [XLEN-1:0]  RF_WData,
    output logic [CNT_W-1:0] RetireCount
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t             state, state_next;
    logic [4:0]         rd_q;
    logic [2:0]         funct3_q;
    logic [OFF_W-1:0]   byteoff_q;

    logic               complete;
    logic               capture;
    logic               wr_en;
    logic [4:0]         wr_addr;
    logic [XLEN-1:0]    wr_data;
    logic               is_load;

    // Extraction is done at 64 bits so that on XLEN=32 the 32-bit cases cover the full word
    // and LD/111 collapse onto LW after truncation; bytes shifted in from above are zero.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0]  data,
        input logic [2:0]       f3,
        input logic [OFF_W-1:0] off
    );
        logic [63:0] sh;
        logic [63:0] r;
        sh = 64'(data) >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{56{sh[7]}},  sh[7:0]};
            3'b001:  r = {{48{sh[15]}}, sh[15:0]};
            3'b010:  r = {{32{sh[31]}}, sh[31:0]};
            3'b100:  r = {56'd0, sh[7:0]};
            3'b101:  r = {48'd0, sh[15:0]};
            3'b110:  r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r[XLEN-1:0];
    endfunction

    assign is_load = (ResultSrcW == 2'b01) && RegWriteW;
    assign ReadyW  = (state == IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next = state;
        complete   = 1'b0;
        capture    = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = RD_W;
        wr_data    = ALU_ResultW;
        case (state)
            IDLE: begin
                if (ValidW) begin
                    if (is_load) begin
                        if (ReadValidW) begin
                            complete = 1'b1;
                            wr_en    = (RD_W != 5'd0);
                            wr_data  = extract_load(ReadDataW, Funct3W, ByteOffW);
                        end else begin
                            capture    = 1'b1;
                            state_next = WAIT_MEM;
                        end
                    end else begin
                        complete = 1'b1;
                        wr_en    = RegWriteW && (RD_W != 5'd0);
                        wr_data  = (ResultSrcW == 2'b10) ? PCPlus4W : ALU_ResultW;
                    end
                end
            end
            WAIT_MEM: begin
                // Only loads with RegWriteW=1 ever park here, so the write enable depends on rd alone.
                if (ReadValidW) begin
                    complete   = 1'b1;
                    wr_en      = (rd_q != 5'd0);
                    wr_addr    = rd_q;
                    wr_data    = extract_load(ReadDataW, funct3_q, byteoff_q);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RF_WE       <= 1'b0;
            RF_Addr     <= 5'd0;
            RF_WData    <= '0;
            RetireCount <= '0;
        end else begin
            RF_WE <= complete && wr_en;
            if (complete) begin
                RF_Addr     <= wr_addr;
                RF_WData    <= wr_data;
                RetireCount <= RetireCount + CNT_W'(1);
            end
        end
    end

    // NOTE: captured load fields need no reset; they are only read in WAIT_MEM, which is entered by capturing them.
    always_ff @(posedge clk) begin
        if (capture) begin
            rd_q      <= RD_W;
            funct3_q  <= Funct3W;
            byteoff_q <= ByteOffW;
        end
    end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: directed spec vectors plus randomized traffic checked
// against a transaction-level model; a second XLEN=32, CNT_W=4 instance covers wrap and RV32 loads.
module tb_wb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance: XLEN=64, CNT_W=32
    logic        valid, ready, regwrite, rvalid, rf_we;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] alu, pc4, rdata, rf_wdata;
    logic [4:0]  rd, rf_addr;
    logic [31:0] rcount;

    wb_writeback_unit #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ValidW(valid), .ReadyW(ready), .RegWriteW(regwrite),
        .ResultSrcW(src), .Funct3W(f3), .ByteOffW(off), .ALU_ResultW(alu), .PCPlus4W(pc4),
        .ReadDataW(rdata), .ReadValidW(rvalid), .RD_W(rd), .RF_WE(rf_we), .RF_Addr(rf_addr),
        .RF_WData(rf_wdata), .RetireCount(rcount)
    );

    // Small instance: XLEN=32, CNT_W=4
    logic        s_valid, s_ready, s_regwrite, s_rvalid, s_we;
    logic [1:0]  s_src;
    logic [2:0]  s_f3;
    logic [1:0]  s_off;
    logic [31:0] s_alu, s_pc4, s_rdata, s_wdata;
    logic [4:0]  s_rd, s_addr;
    logic [3:0]  s_cnt;

    wb_writeback_unit #(.XLEN(32), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .ValidW(s_valid), .ReadyW(s_ready), .RegWriteW(s_regwrite),
        .ResultSrcW(s_src), .Funct3W(s_f3), .ByteOffW(s_off), .ALU_ResultW(s_alu), .PCPlus4W(s_pc4),
        .ReadDataW(s_rdata), .ReadValidW(s_rvalid), .RD_W(s_rd), .RF_WE(s_we), .RF_Addr(s_addr),
        .RF_WData(s_wdata), .RetireCount(s_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the main instance, tracked per instruction
    bit          m_pend;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    int          m_off;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    logic [31:0] m_cnt;

    function automatic logic [63:0] model_load(logic [63:0] d, logic [2:0] fn, int byte_off);
        logic [63:0] sh, v;
        int          bits;
        bit          sgn;
        sh = d >> (8 * byte_off);
        case (fn)
            3'd0:    begin bits = 8;  sgn = 1; end
            3'd1:    begin bits = 16; sgn = 1; end
            3'd2:    begin bits = 32; sgn = 1; end
            3'd4:    begin bits = 8;  sgn = 0; end
            3'd5:    begin bits = 16; sgn = 0; end
            3'd6:    begin bits = 32; sgn = 0; end
            default: begin bits = 64; sgn = 0; end
        endcase
        if (bits == 64) return sh;
        v = sh & ((64'd1 << bits) - 64'd1);
        if (sgn && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
        return v;
    endfunction

    task automatic retire(bit writes, logic [4:0] dest, logic [63:0] value);
        m_we   = writes && (dest != 5'd0);
        m_addr = dest;
        m_data = value;
        m_cnt  = m_cnt + 32'd1;
    endtask

    // Predict the effect of the currently driven inputs, then advance one clock.
    task automatic tick();
        if (!rst_n) begin
            m_pend = 0; m_we = 0; m_addr = '0; m_data = '0; m_cnt = '0;
        end else begin
            m_we = 0;
            if (m_pend) begin
                if (rvalid) begin
                    retire(1, m_rd, model_load(rdata, m_f3, m_off));
                    m_pend = 0;
                end
            end else if (valid) begin
                if (src == 2'b01 && regwrite) begin
                    if (rvalid) retire(1, rd, model_load(rdata, f3, int'(off)));
                    else begin
                        m_pend = 1; m_rd = rd; m_f3 = f3; m_off = int'(off);
                    end
                end else begin
                    retire(regwrite, rd, (src == 2'b10) ? pc4 : alu);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        valid = 0; regwrite = 0; src = 0; f3 = 0; off = 0; alu = 0; pc4 = 0;
        rdata = 0; rvalid = 0; rd = 0;
        s_valid = 0; s_regwrite = 0; s_src = 0; s_f3 = 0; s_off = 0; s_alu = 0; s_pc4 = 0;
        s_rdata = 0; s_rvalid = 0; s_rd = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", rf_we); end
        n_cmp++; if (rf_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rf_addr); end
        n_cmp++; if (rf_wdata !== 64'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        n_cmp++; if (rcount !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", rcount); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_alu_op();
        valid = 1; regwrite = 1; src = 2'b00; rd = 5; alu = 64'h1234;
        tick();
        drive_idle();
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL alu_we: got %b want 1", rf_we); end
        n_cmp++; if (rf_addr !== 5'd5) begin n_err++; $display("FAIL alu_addr: got %0d want 5", rf_addr); end
        n_cmp++; if (rf_wdata !== 64'h1234) begin n_err++; $display("FAIL alu_wdata: got %h want 1234", rf_wdata); end
        n_cmp++; if (rcount !== 32'd1) begin n_err++; $display("FAIL alu_count: got %0d want 1", rcount); end
        tick();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL alu_we_pulse: got %b want 0", rf_we); end
        n_cmp++; if (rf_wdata !== 64'h1234) begin n_err++; $display("FAIL alu_hold: got %h want 1234", rf_wdata); end
    endtask

    task automatic test_load_same_cycle();
        logic [63:0] want [2];
        want[0] = 64'hFFFFFFFF_FFFFFF80;
        want[1] = 64'h00000000_00000080;
        for (int i = 0; i < 2; i++) begin
            valid = 1; regwrite = 1; src = 2'b01; f3 = (i == 0) ? 3'b000 : 3'b100; off = 3;
            rdata = 64'h00000000_80000000; rvalid = 1; rd = 5'd10 + 5'(i);
            tick();
            drive_idle();
            n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL ld_now_we[%0d]: got %b want 1", i, rf_we); end
            n_cmp++; if (rf_wdata !== want[i]) begin n_err++; $display("FAIL ld_now_data[%0d]: got %h want %h", i, rf_wdata, want[i]); end
            n_cmp++; if (rf_wdata !== m_data) begin n_err++; $display("FAIL ld_now_model[%0d]: got %h want %h", i, rf_wdata, m_data); end
        end
    endtask

    task automatic test_load_wait();
        logic [31:0] cnt_before;
        valid = 1; regwrite = 1; src = 2'b01; f3 = 3'b010; off = 0; rd = 7; rvalid = 0;
        tick();
        cnt_before = m_cnt;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL wait_ready[%0d]: got %b want 0", i, ready); end
            valid = 1; regwrite = 1; src = 2'b00; rd = 9; alu = 64'(32'hBAD0 + i); rvalid = 0;
            tick();
            n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL wait_we[%0d]: got %b want 0", i, rf_we); end
        end
        n_cmp++; if (rcount !== cnt_before) begin n_err++; $display("FAIL wait_count: got %0d want %0d", rcount, cnt_before); end
        valid = 1; src = 2'b00; rd = 9; rvalid = 1; rdata = 64'h00000000_DEADBEEF;
        tick();
        drive_idle();
        n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL wait_done_we: got %b want 1", rf_we); end
        n_cmp++; if (rf_addr !== 5'd7) begin n_err++; $display("FAIL wait_done_addr: got %0d want 7", rf_addr); end
        n_cmp++; if (rf_wdata !== 64'hFFFFFFFF_DEADBEEF) begin n_err++; $display("FAIL wait_done_data: got %h want ffffffffdeadbeef", rf_wdata); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL wait_done_ready: got %b want 1", ready); end
        n_cmp++; if (rcount !== cnt_before + 32'd1) begin n_err++; $display("FAIL wait_done_count: got %0d want %0d", rcount, cnt_before + 1); end
    endtask

    task automatic test_jal_and_x0();
        logic [31:0] c0;
        valid = 1; regwrite = 1; src = 2'b10; pc4 = 64'h104; alu = 64'h5555; rd = 1;
        tick();
        n_cmp++; if (rf_wdata !== 64'h104 || rf_we !== 1'b1 || rf_addr !== 5'd1) begin
            n_err++; $display("FAIL jal: got we=%b addr=%0d data=%h want we=1 addr=1 data=104", rf_we, rf_addr, rf_wdata);
        end
        c0 = m_cnt;
        src = 2'b00; rd = 0; alu = 64'h77;
        tick();
        drive_idle();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL x0_we: got %b want 0", rf_we); end
        n_cmp++; if (rcount !== c0 + 32'd1) begin n_err++; $display("FAIL x0_count: got %0d want %0d", rcount, c0 + 1); end
    endtask

    task automatic test_reset_in_wait();
        valid = 1; regwrite = 1; src = 2'b01; f3 = 3'b011; rd = 12; rvalid = 0;
        tick();
        drive_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        rvalid = 1; rdata = 64'h1122334455667788;
        tick();
        drive_idle();
        n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rstwait_we: got %b want 0", rf_we); end
        n_cmp++; if (rcount !== 32'd0) begin n_err++; $display("FAIL rstwait_count: got %0d want 0", rcount); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstwait_ready: got %b want 1", ready); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            valid = 1; regwrite = 1; src = 2'b00; rd = 5'(i + 1); alu = 64'(i * 3 + 100);
            tick();
            n_cmp++; if (rf_we !== 1'b1 || rf_addr !== 5'(i + 1) || rf_wdata !== 64'(i * 3 + 100)) begin
                n_err++; $display("FAIL b2b[%0d]: got we=%b addr=%0d data=%h", i, rf_we, rf_addr, rf_wdata);
            end
            n_cmp++; if (rcount !== m_cnt) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, rcount, m_cnt); end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_err;
        for (int i = 0; i < 400; i++) begin
            valid    = ($urandom_range(0, 9) < 7);
            regwrite = ($urandom_range(0, 3) != 0);
            src      = 2'($urandom_range(0, 3));
            f3       = 3'($urandom_range(0, 7));
            off      = 3'($urandom_range(0, 7));
            alu      = {$urandom, $urandom};
            pc4      = {$urandom, $urandom};
            rdata    = {$urandom, $urandom};
            rvalid   = ($urandom_range(0, 9) < 4);
            rd       = 5'($urandom_range(0, 31));
            tick();
            n_cmp++;
            if (rf_we !== m_we || ready !== !m_pend || rcount !== m_cnt ||
                (m_we && (rf_addr !== m_addr || rf_wdata !== m_data))) begin
                n_err++;
                if (n_err - errs_before <= 5)
                    $display("FAIL random[%0d]: got we=%b rdy=%b cnt=%0d addr=%0d data=%h want we=%b rdy=%b cnt=%0d addr=%0d data=%h",
                             i, rf_we, ready, rcount, rf_addr, rf_wdata, m_we, !m_pend, m_cnt, m_addr, m_data);
            end
        end
        drive_idle();
        rvalid = 1;
        tick();
        drive_idle();
    endtask

    task automatic test_small_xlen32_wrap();
        logic [2:0]  t_f3   [5];
        logic [1:0]  t_off  [5];
        logic [31:0] t_data [5];
        logic [31:0] t_want [5];
        t_f3[0] = 3'b011; t_off[0] = 0; t_data[0] = 32'h80000001; t_want[0] = 32'h80000001;
        t_f3[1] = 3'b011; t_off[1] = 2; t_data[1] = 32'hABCD1234; t_want[1] = 32'h0000ABCD;
        t_f3[2] = 3'b111; t_off[2] = 1; t_data[2] = 32'h80FF0102; t_want[2] = 32'h0080FF01;
        t_f3[3] = 3'b110; t_off[3] = 0; t_data[3] = 32'hF0000000; t_want[3] = 32'hF0000000;
        t_f3[4] = 3'b001; t_off[4] = 2; t_data[4] = 32'hABCD1234; t_want[4] = 32'hFFFFABCD;
        drive_idle();
        rst_n = 0;
        tick();
        rst_n = 1;
        for (int i = 0; i < 17; i++) begin
            s_valid = 1; s_regwrite = 1; s_src = 2'b00; s_rd = 3; s_alu = 32'(i);
            tick();
        end
        n_cmp++; if (s_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_count: got %0d want 1", s_cnt); end
        for (int i = 0; i < 5; i++) begin
            s_valid = 1; s_regwrite = 1; s_src = 2'b01; s_rd = 4; s_rvalid = 1;
            s_f3 = t_f3[i]; s_off = t_off[i]; s_rdata = t_data[i];
            tick();
            n_cmp++; if (s_we !== 1'b1 || s_wdata !== t_want[i]) begin
                n_err++; $display("FAIL rv32_load[%0d]: got we=%b data=%h want we=1 data=%h", i, s_we, s_wdata, t_want[i]);
            end
        end
        drive_idle();
        n_cmp++; if (s_cnt !== 4'd6) begin n_err++; $display("FAIL rv32_count: got %0d want 6", s_cnt); end
    endtask

    initial begin
        drive_idle();
        rst_n = 0;
        test_reset();
        test_alu_op();
        test_load_same_cycle();
        test_load_wait();
        test_jal_and_x0();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        test_small_xlen32_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
